door_input_conditioner: RTL and testbench



---
 rtl/door_input_conditioner.sv | 165 ++++++++++++++++
 tb/tb_door_input_conditioner.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/door_input_conditioner.sv
// Input front-end for the door controller: synchronises and debounces the two
// pushbuttons and two end-position sensors, producing press pulses and clean sensor levels.

module door_debounce #(
    parameter int DEB = 4
) (
    input  logic clk2m,
    input  logic rst_n,
    input  logic sample,
    output logic stable,
    output logic stable_next
);
    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB - 1);

    logic [CW-1:0] cnt_r;
    logic          stable_r;

    // Combinational view of the level that will be accepted on the coming edge
    always_comb begin
        stable_next = stable_r;
        if ((sample != stable_r) && (cnt_r == CNT_MAX)) begin
            stable_next = sample;
        end else begin
            stable_next = stable_r;
        end
    end

    // Stability counter: any return to the accepted level restarts the count
    always_ff @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            stable_r <= 1'b0;
        end else if (sample == stable_r) begin
            cnt_r    <= {CW{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            stable_r <= sample;
            cnt_r    <= {CW{1'b0}};
        end else begin
            cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign stable = stable_r;
endmodule

module door_input_conditioner #(
    parameter int DEB_KEY        = 20000,
    parameter int DEB_SENSE      = 200,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic clk2m,
    input  logic rst_n,
    input  logic key_up_raw,
    input  logic key_down_raw,
    input  logic sense_up_raw,
    input  logic sense_down_raw,
    output logic key_up,
    output logic key_down,
    output logic sense_up,
    output logic sense_down,
    output logic sensor_fault
);
    // Channel order: [0] key_up, [1] key_down, [2] sense_up, [3] sense_down.
    // Synchroniser flops idle at the raw inactive level; KEY_INV maps keys to active-high.
    localparam logic [3:0] KEY_INV = (KEY_ACTIVE_LOW != 0) ? 4'b0011 : 4'b0000;

    logic [3:0] sync1_r;
    logic [3:0] sync2_r;
    logic [3:0] sample_s;
    logic [3:0] stable_s;
    logic [3:0] next_s;
    logic [1:0] warm_r;
    logic [1:0] armed_r;
    logic       key_up_r;
    logic       key_down_r;
    logic       sense_up_r;
    logic       sense_down_r;
    logic       fault_r;
    logic       fire_up_s;
    logic       fire_down_s;
    logic       fault_next_s;

    // Two-flop synchroniser for all four raw inputs
    always_ff @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= KEY_INV;
            sync2_r <= KEY_INV;
        end else begin
            sync1_r <= {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw};
            sync2_r <= sync1_r;
        end
    end

    assign sample_s = sync2_r ^ KEY_INV;

    door_debounce #(.DEB(DEB_KEY)) u_deb_key_up (
        .clk2m(clk2m), .rst_n(rst_n), .sample(sample_s[0]),
        .stable(stable_s[0]), .stable_next(next_s[0])
    );
    door_debounce #(.DEB(DEB_KEY)) u_deb_key_down (
        .clk2m(clk2m), .rst_n(rst_n), .sample(sample_s[1]),
        .stable(stable_s[1]), .stable_next(next_s[1])
    );
    door_debounce #(.DEB(DEB_SENSE)) u_deb_sense_up (
        .clk2m(clk2m), .rst_n(rst_n), .sample(sample_s[2]),
        .stable(stable_s[2]), .stable_next(next_s[2])
    );
    door_debounce #(.DEB(DEB_SENSE)) u_deb_sense_down (
        .clk2m(clk2m), .rst_n(rst_n), .sample(sample_s[3]),
        .stable(stable_s[3]), .stable_next(next_s[3])
    );

    // A key is armed only once it has been seen released after reset, so a key
    // held through reset release never produces a press pulse.
    always_ff @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
            warm_r  <= 2'b00;
            armed_r <= 2'b00;
        end else begin
            warm_r  <= {warm_r[0], 1'b1};
            armed_r <= armed_r | ({2{warm_r[1]}} & ~sample_s[1:0]);
        end
    end

    // Press acceptance with mutual exclusion between the two keys
    always_comb begin
        fire_up_s    = 1'b0;
        fire_down_s  = 1'b0;
        fault_next_s = next_s[2] & next_s[3];
        if (armed_r[0] && next_s[0] && !stable_s[0] && !(next_s[1] && !stable_s[1]) && !stable_s[1]) begin
            fire_up_s = 1'b1;
        end else begin
            fire_up_s = 1'b0;
        end
        if (armed_r[1] && next_s[1] && !stable_s[1] && !(next_s[0] && !stable_s[0]) && !stable_s[0]) begin
            fire_down_s = 1'b1;
        end else begin
            fire_down_s = 1'b0;
        end
    end

    // Registered outputs, updated on the same edge as the debounced levels
    always_ff @(posedge clk2m or negedge rst_n) begin
        if (!rst_n) begin
            key_up_r     <= 1'b0;
            key_down_r   <= 1'b0;
            sense_up_r   <= 1'b0;
            sense_down_r <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            key_up_r     <= fire_up_s;
            key_down_r   <= fire_down_s;
            sense_up_r   <= next_s[2] & ~fault_next_s;
            sense_down_r <= next_s[3] & ~fault_next_s;
            fault_r      <= fault_next_s;
        end
    end

    assign key_up       = key_up_r;
    assign key_down     = key_down_r;
    assign sense_up     = sense_up_r;
    assign sense_down   = sense_down_r;
    assign sensor_fault = fault_r;
endmodule

// File: tb/tb_door_input_conditioner.sv
// Scoreboard bench for door_input_conditioner with DEB_KEY=4, DEB_SENSE=2, active-low keys.

module tb_door_input_conditioner;
    logic clk2m = 1'b0;
    logic rst_n = 1'b0;
    logic key_up_raw = 1'b1;
    logic key_down_raw = 1'b1;
    logic sense_up_raw = 1'b0;
    logic sense_down_raw = 1'b0;
    logic key_up, key_down, sense_up, sense_down, sensor_fault;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;

    always #5 clk2m = ~clk2m;

    door_input_conditioner #(
        .DEB_KEY(4), .DEB_SENSE(2), .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk2m(clk2m), .rst_n(rst_n),
        .key_up_raw(key_up_raw), .key_down_raw(key_down_raw),
        .sense_up_raw(sense_up_raw), .sense_down_raw(sense_down_raw),
        .key_up(key_up), .key_down(key_down),
        .sense_up(sense_up), .sense_down(sense_down), .sensor_fault(sensor_fault)
    );

    function automatic logic [4:0] outs();
        return {key_up, key_down, sense_up, sense_down, sensor_fault};
    endfunction

    // raw = {key_up_raw, key_down_raw, sense_up_raw, sense_down_raw}
    task automatic drive(input logic [3:0] raw);
        {key_up_raw, key_down_raw, sense_up_raw, sense_down_raw} = raw;
    endtask

    // exp = {key_up, key_down, sense_up, sense_down, sensor_fault} after this edge
    task automatic cyc(input logic [3:0] raw, input logic [4:0] exp);
        drive(raw);
        @(posedge clk2m);
        exp_q.push_back(exp);
        #1;
    endtask

    task automatic rep(input int n, input logic [3:0] raw, input logic [4:0] exp);
        for (int i = 0; i < n; i++) cyc(raw, exp);
    endtask

    task automatic do_reset(input logic [3:0] raw, input string tag);
        @(negedge clk2m);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs() !== 5'b00000) begin
            errors++;
            $display("FAIL %s: outputs %b during reset, required 00000", tag, outs());
        end
        drive(raw);
        @(posedge clk2m);
        @(negedge clk2m);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare each cycle's outputs against the queued expectation
    always @(negedge clk2m) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            checks++;
            if (outs() !== mon_exp) begin
                errors++;
                $display("FAIL cycle_outputs at %0t: got %b required %b", $time, outs(), mon_exp);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk2m);
        do_reset(4'b1100, "reset_init");
        rep(6, 4'b1100, 5'b00000);

        // Clean key_up press: one pulse after edge 6, none while held or on release
        rep(5, 4'b0100, 5'b00000);
        cyc(4'b0100, 5'b10000);
        rep(44, 4'b0100, 5'b00000);
        rep(10, 4'b1100, 5'b00000);

        // key_down bounce rejected, then a clean 6-cycle hold pulses once
        rep(3, 4'b1000, 5'b00000);
        rep(2, 4'b1100, 5'b00000);
        rep(3, 4'b1000, 5'b00000);
        rep(10, 4'b1100, 5'b00000);
        rep(5, 4'b1000, 5'b00000);
        cyc(4'b1000, 5'b01000);
        rep(10, 4'b1100, 5'b00000);

        // key_up press while key_down is held is suppressed
        rep(5, 4'b1000, 5'b00000);
        cyc(4'b1000, 5'b01000);
        rep(4, 4'b1000, 5'b00000);
        rep(12, 4'b0000, 5'b00000);
        rep(10, 4'b1100, 5'b00000);

        // Simultaneous press: no pulse; after release a lone press works
        rep(12, 4'b0000, 5'b00000);
        rep(10, 4'b1100, 5'b00000);
        rep(5, 4'b0100, 5'b00000);
        cyc(4'b0100, 5'b10000);
        rep(5, 4'b0100, 5'b00000);
        rep(10, 4'b1100, 5'b00000);

        // Sensor debounce and plausibility fault
        rep(3, 4'b1110, 5'b00000);
        cyc(4'b1110, 5'b00100);
        rep(4, 4'b1110, 5'b00100);
        rep(3, 4'b1111, 5'b00100);
        cyc(4'b1111, 5'b00001);
        rep(4, 4'b1111, 5'b00001);
        rep(3, 4'b1110, 5'b00001);
        cyc(4'b1110, 5'b00100);
        rep(4, 4'b1110, 5'b00100);
        rep(3, 4'b1100, 5'b00100);
        cyc(4'b1100, 5'b00000);
        rep(3, 4'b1100, 5'b00000);

        // Reset mid-debounce with key held: no pulse afterwards until re-press
        rep(3, 4'b1110, 5'b00000);
        cyc(4'b1110, 5'b00100);
        rep(4, 4'b0110, 5'b00100);
        do_reset(4'b0110, "reset_mid_debounce");
        rep(3, 4'b0110, 5'b00000);
        cyc(4'b0110, 5'b00100);
        rep(16, 4'b0110, 5'b00100);
        rep(10, 4'b1110, 5'b00100);
        rep(5, 4'b0110, 5'b00100);
        cyc(4'b0110, 5'b10100);
        rep(3, 4'b0110, 5'b00100);
        rep(10, 4'b1110, 5'b00100);

        // Reset release with both sensors active: fault, senses stay low
        do_reset(4'b1111, "reset_sensors");
        rep(3, 4'b1111, 5'b00000);
        cyc(4'b1111, 5'b00001);
        rep(5, 4'b1111, 5'b00001);
        rep(3, 4'b1100, 5'b00001);
        cyc(4'b1100, 5'b00000);
        rep(3, 4'b1100, 5'b00000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk2m);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expectations pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
